// File: rtl/multisim_arb_pkg.sv
// multisim_arb_pkg: shared state encoding and limits for the pull-channel arbiter
package multisim_arb_pkg;
   localparam int MAX_PORTS = 16;
   typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_DELIVER} arb_state_e;
endpackage

// File: rtl/multisim_rr_picker.sv
// multisim_rr_picker: first eligible port after last_grant, wrapping modulo N_PORTS
module multisim_rr_picker #(
   parameter int N_PORTS = 4,
   parameter int IW      = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] eligible,
   input  logic [IW-1:0]      last_grant,
   output logic [IW-1:0]      pick,
   output logic               any_eligible
);
   logic [IW-1:0] idx;
   // Scan farthest-to-nearest so the nearest eligible port is written last and wins.
   always_comb begin
      pick = '0;
      idx = '0;
      any_eligible = |eligible;
      for (int k = N_PORTS; k >= 1; k--) begin
         idx = IW'((int'(last_grant) + k) % N_PORTS);
         if (eligible[idx]) pick = idx;
      end
   end
endmodule

// File: rtl/multisim_pull_arbiter.sv
// multisim_pull_arbiter: credit-based round-robin sharing of one upstream pull channel
module multisim_pull_arbiter
   import multisim_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int N_PORTS      = 4,
   parameter int CREDIT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  up_data_vld,
   input  logic [DATA_WIDTH-1:0] up_data,
   output logic                  up_data_rdy,
   input  logic [N_PORTS-1:0]    credit_inc,
   output logic [N_PORTS-1:0]    dn_vld,
   input  logic [N_PORTS-1:0]    dn_rdy,
   output logic [DATA_WIDTH-1:0] dn_data,
   output logic [N_PORTS-1:0]    credit_ovf
);
   localparam int IW = $clog2(N_PORTS);
   localparam logic [CREDIT_WIDTH-1:0] CMAX = '1;

   if (N_PORTS < 2 || N_PORTS > MAX_PORTS) begin : g_bad_ports
      $error("multisim_pull_arbiter: N_PORTS out of range");
   end

   arb_state_e state_q, state_d;
   logic [N_PORTS-1:0][CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic [N_PORTS-1:0] ovf_q, ovf_d, dn_vld_q, dn_vld_d, eligible, pick_elig, dec;
   logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick_last, pick;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic rdy_q, rdy_d, any_elig, capture;

   assign capture = (state_q == ARB_FETCH) && up_data_vld;
   // Re-arbitration out of DELIVER already counts this cycle's credit pulses.
   assign pick_elig = (state_q == ARB_DELIVER) ? (eligible | credit_inc) : eligible;
   assign pick_last = (state_q == ARB_DELIVER) ? grant_q : last_q;

   multisim_rr_picker #(.N_PORTS(N_PORTS), .IW(IW)) u_picker (
      .eligible     (pick_elig),
      .last_grant   (pick_last),
      .pick         (pick),
      .any_eligible (any_elig)
   );

   always_comb begin
      dec = '0;
      if (capture) dec[grant_q] = 1'b1;
      credit_d = credit_q;
      ovf_d = ovf_q;
      for (int i = 0; i < N_PORTS; i++) begin
         eligible[i] = credit_q[i] != '0;
         if (credit_inc[i] && !dec[i]) begin
            if (credit_q[i] == CMAX) ovf_d[i] = 1'b1;
            else credit_d[i] = credit_q[i] + 1'b1;
         end else if (dec[i] && !credit_inc[i]) begin
            credit_d[i] = credit_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d = last_q;
      out_d = out_q;
      rdy_d = rdy_q;
      dn_vld_d = dn_vld_q;
      case (state_q)
         ARB_IDLE: if (any_elig) begin
            grant_d = pick;
            rdy_d = 1'b1;
            state_d = ARB_FETCH;
         end
         ARB_FETCH: if (up_data_vld) begin
            out_d = up_data;
            rdy_d = 1'b0;
            dn_vld_d = '0;
            dn_vld_d[grant_q] = 1'b1;
            state_d = ARB_DELIVER;
         end
         ARB_DELIVER: if (dn_rdy[grant_q]) begin
            last_d = grant_q;
            dn_vld_d = '0;
            out_d = '0;
            grant_d = any_elig ? pick : grant_q;
            rdy_d = any_elig;
            state_d = any_elig ? ARB_FETCH : ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         credit_q <= '0;
         ovf_q <= '0;
         dn_vld_q <= '0;
         grant_q <= '0;
         last_q <= IW'(N_PORTS - 1);
         out_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         credit_q <= credit_d;
         ovf_q <= ovf_d;
         dn_vld_q <= dn_vld_d;
         grant_q <= grant_d;
         last_q <= last_d;
         out_q <= out_d;
         rdy_q <= rdy_d;
      end
   end

   assign up_data_rdy = rdy_q;
   assign dn_vld = dn_vld_q;
   assign dn_data = out_q;
   assign credit_ovf = ovf_q;
endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// tb_multisim_pull_arbiter: scoreboard bench with a transaction-level arbiter model
module tb_multisim_pull_arbiter;
   localparam int DW = 64, NP = 4, CW = 4, CMAX = 15;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic up_data_vld, up_data_rdy;
   logic [DW-1:0] up_data, dn_data;
   logic [NP-1:0] credit_inc, dn_vld, dn_rdy, credit_ovf;

   multisim_pull_arbiter #(.DATA_WIDTH(DW), .N_PORTS(NP), .CREDIT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .up_data_vld(up_data_vld), .up_data(up_data),
      .up_data_rdy(up_data_rdy), .credit_inc(credit_inc), .dn_vld(dn_vld),
      .dn_rdy(dn_rdy), .dn_data(dn_data), .credit_ovf(credit_ovf)
   );

   int checks = 0, failures = 0, cyc = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {int port; logic [63:0] data;} beat_t;
   beat_t exp_q[$];
   int got_port[$], got_cyc[$];
   logic [63:0] got_data[$];

   // Reference model: credits per port, whose turn it is, and which phase the channel is in.
   int m_cred[NP];
   bit [NP-1:0] m_ovf;
   int m_last, m_grant, m_phase;

   function automatic int rr_pick(bit [NP-1:0] el, int from);
      for (int k = 1; k <= NP; k++) if (el[(from + k) % NP]) return (from + k) % NP;
      return -1;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         foreach (m_cred[i]) m_cred[i] = 0;
         m_ovf = '0;
         m_last = NP - 1;
         m_grant = 0;
         m_phase = 0;
         exp_q.delete();
      end else begin
         int cap, p, delta;
         bit [NP-1:0] el;
         cap = -1;
         foreach (m_cred[i]) el[i] = m_cred[i] > 0;
         if (m_phase == 0) begin
            p = rr_pick(el, m_last);
            if (p >= 0) begin m_grant = p; m_phase = 1; end
         end else if (m_phase == 1) begin
            if (up_data_vld) begin
               cap = m_grant;
               exp_q.push_back('{port: m_grant, data: up_data});
               m_phase = 2;
            end
         end else if (dn_rdy[m_grant]) begin
            m_last = m_grant;
            p = rr_pick(el | credit_inc, m_grant);
            if (p >= 0) begin m_grant = p; m_phase = 1; end
            else m_phase = 0;
         end
         foreach (m_cred[i]) begin
            delta = int'(credit_inc[i]) - int'(cap == i);
            if (delta > 0) begin
               if (m_cred[i] == CMAX) m_ovf[i] = 1'b1;
               else m_cred[i]++;
            end else if (delta < 0) m_cred[i]--;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: per-cycle handshake/flag checks and scoreboard pops on delivery.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("up_data_rdy", up_data_rdy, m_phase == 1);
         check("dn_vld", dn_vld, m_phase == 2 ? 64'(1 << m_grant) : 64'd0);
         check("credit_ovf", credit_ovf, m_ovf);
         for (int p = 0; p < NP; p++) if (dn_vld[p] && dn_rdy[p]) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL delivery port=%0d data=%0h with no expected beat", p, dn_data);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("dn_port", p, e.port);
               check("dn_data", dn_data, e.data);
            end
            got_port.push_back(p);
            got_data.push_back(dn_data);
            got_cyc.push_back(cyc);
         end
      end
   end

   int srv_mode;
   logic [63:0] srv_cnt;

   task automatic drive_up();
      up_data_vld = srv_mode != 0 && (srv_mode != 2 || $urandom_range(9) < 7);
      up_data = srv_mode == 2 ? {$urandom, $urandom} : srv_cnt;
   endtask

   task automatic tick();
      bit acc;
      @(negedge clk);
      acc = up_data_vld && up_data_rdy;
      @(posedge clk);
      #1;
      if (acc && srv_mode == 1) srv_cnt++;
      drive_up();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      credit_inc = '0;
      dn_rdy = '0;
      srv_mode = 0;
      drive_up();
      tick();
      tick();
      rst_n = 1'b1;
      got_port.delete();
      got_data.delete();
      got_cyc.delete();
   endtask

   task automatic wait_got(int n, int budget, string name);
      int k = 0;
      while (got_data.size() < n && k < budget) begin tick(); k++; end
      checks++;
      if (got_data.size() < n) begin
         failures++;
         $display("FAIL %s timeout: delivered=%0d required=%0d", name, got_data.size(), n);
      end
   endtask

   task automatic wait_vld(int p, int budget, string name);
      int k = 0;
      while (!dn_vld[p] && k < budget) begin tick(); k++; end
      check({name, "_vld_timeout"}, dn_vld[p], 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      credit_inc = '0;
      dn_rdy = '0;
      srv_mode = 0;
      srv_cnt = '0;
      drive_up();
      repeat (3) @(posedge clk);
      #1;
      check("rst_up_data_rdy", up_data_rdy, 0);
      check("rst_dn_vld", dn_vld, 0);
      check("rst_dn_data", dn_data, 0);
      check("rst_credit_ovf", credit_ovf, 0);
      rst_n = 1'b1;

      // Single port, three credits, beats A,B,C at one per two cycles.
      srv_mode = 1;
      srv_cnt = 64'hA;
      dn_rdy = 4'b0001;
      drive_up();
      credit_inc = 4'b0001;
      repeat (3) tick();
      credit_inc = '0;
      wait_got(3, 40, "single_port");
      if (got_data.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("t1_data", got_data[i], 64'hA + 64'(i));
            check("t1_port", got_port[i], 0);
         end
         check("t1_gap1", got_cyc[1] - got_cyc[0], 2);
         check("t1_gap2", got_cyc[2] - got_cyc[1], 2);
      end
      repeat (4) tick();
      check("t1_idle_rdy", up_data_rdy, 0);
      check("t1_idle_vld", dn_vld, 0);
      check("t1_srv_left", srv_cnt, 64'hD);

      // Four ports, two credits each: strict rotation 0..3 twice.
      do_reset();
      srv_mode = 1;
      srv_cnt = 0;
      dn_rdy = '1;
      drive_up();
      credit_inc = '1;
      repeat (2) tick();
      credit_inc = '0;
      wait_got(8, 60, "rotation");
      if (got_data.size() >= 8)
         for (int i = 0; i < 8; i++) begin
            check("t2_port", got_port[i], i % NP);
            check("t2_data", got_data[i], 64'(i));
         end

      // Port 2 stalls delivery; port 0 waits behind it.
      do_reset();
      srv_mode = 1;
      srv_cnt = 100;
      dn_rdy = 4'b1011;
      drive_up();
      credit_inc = 4'b0100;
      tick();
      credit_inc = '0;
      wait_vld(2, 20, "t3");
      credit_inc = 4'b0001;
      tick();
      credit_inc = '0;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_vld", dn_vld, 4'b0100);
         check("t3_hold_data", dn_data, 100);
         check("t3_hold_rdy", up_data_rdy, 0);
         tick();
      end
      dn_rdy = '1;
      wait_got(2, 20, "stall");
      if (got_data.size() >= 2) begin
         check("t3_first_port", got_port[0], 2);
         check("t3_first_data", got_data[0], 100);
         check("t3_second_port", got_port[1], 0);
         check("t3_second_data", got_data[1], 101);
      end

      // Port 1 at max: inc+capture together is neutral, a lone inc overflows.
      do_reset();
      credit_inc = 4'b0010;
      repeat (15) tick();
      check("t4_no_ovf_at_max", credit_ovf, 0);
      srv_mode = 1;
      srv_cnt = 200;
      drive_up();
      tick();
      credit_inc = '0;
      srv_mode = 0;
      drive_up();
      check("t4_inc_and_capture", credit_ovf, 0);
      credit_inc = 4'b0010;
      tick();
      credit_inc = '0;
      check("t4_ovf_set", credit_ovf, 4'b0010);
      got_data.delete();
      got_port.delete();
      got_cyc.delete();
      dn_rdy = '1;
      srv_mode = 1;
      drive_up();
      wait_got(16, 80, "drain_max");
      repeat (6) tick();
      check("t4_total_beats", got_data.size(), 16);
      check("t4_idle_rdy", up_data_rdy, 0);
      check("t4_ovf_sticky", credit_ovf, 4'b0010);

      // Upstream valid but nobody holds credit.
      do_reset();
      srv_mode = 2;
      dn_rdy = '1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5_no_rdy", up_data_rdy, 0);
         check("t5_no_vld", dn_vld, 0);
      end

      // Reset mid-delivery discards the held beat; the pending upstream beat stays.
      do_reset();
      srv_mode = 1;
      srv_cnt = 300;
      drive_up();
      credit_inc = 4'b0001;
      tick();
      credit_inc = '0;
      wait_vld(0, 20, "t6");
      rst_n = 1'b0;
      #1;
      check("t6_rst_rdy", up_data_rdy, 0);
      check("t6_rst_vld", dn_vld, 0);
      check("t6_rst_data", dn_data, 0);
      check("t6_rst_ovf", credit_ovf, 0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t6_after_vld", dn_vld, 0);
      end
      check("t6_beat_kept", srv_cnt, 301);

      // Randomized traffic against the model.
      do_reset();
      srv_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         credit_inc = NP'($urandom) & NP'($urandom) & NP'($urandom);
         dn_rdy = NP'($urandom) | NP'($urandom);
         tick();
      end
      credit_inc = '0;
      dn_rdy = '1;
      srv_mode = 1;
      drive_up();
      for (int k = 0; k < 400 && !(m_phase == 0 && exp_q.size() == 0); k++) tick();
      repeat (3) tick();
      check("rand_drained_queue", exp_q.size(), 0);
      check("rand_drained_rdy", up_data_rdy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
